// File: rtl/alu_ctrl_decode_if.sv
// Fetch-to-decode handshake plus the decoded ID/EX slot fields.
// The slave side is the decoder; the master side is fetch/execute.
interface alu_ctrl_decode_if #(parameter int CNT_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       aluc;
    logic [31:0]      imm;
    logic             use_imm;
    logic             use_pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             illegal;
    logic [CNT_W-1:0] illegal_count;

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, aluc, imm, use_imm, use_pc,
               rs1, rs2, rd, reg_write, mem_read, mem_write,
               illegal, illegal_count
    );

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, aluc, imm, use_imm, use_pc,
               rs1, rs2, rd, reg_write, mem_read, mem_write,
               illegal, illegal_count
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// RV32I decode of ALU control, immediate and enables into a single ID/EX slot,
// with valid/ready handshake, flush and a saturating illegal-instruction counter.
module alu_ctrl_decode #(
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    alu_ctrl_decode_if.slave   bus
);
    localparam logic [5:0] ALU_ADD = 6'b000000, ALU_SUB = 6'b001000,
                           ALU_AND = 6'b000010, ALU_OR  = 6'b001010,
                           ALU_XOR = 6'b000100, ALU_LUI = 6'b001100,
                           ALU_SLL = 6'b000101, ALU_SRL = 6'b001101,
                           ALU_SRA = 6'b011101;

    localparam logic [6:0] OPC_OP  = 7'b0110011, OPC_OPI   = 7'b0010011,
                           OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                           OPC_LD  = 7'b0000011, OPC_ST    = 7'b0100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000, F7_ALT = 7'b0100000;

    typedef struct packed {
        logic [5:0]  aluc;
        logic [31:0] imm;
        logic        use_imm;
        logic        use_pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } dec_t;

    dec_t             dec, slot;
    logic             vld;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             bad;

    wire [6:0] opc = bus.instr[6:0];
    wire [2:0] f3  = bus.instr[14:12];
    wire [6:0] f7  = bus.instr[31:25];

    always_comb begin
        dec     = '0;
        bad     = 1'b0;
        dec.rs1 = bus.instr[19:15];
        dec.rs2 = bus.instr[24:20];
        dec.rd  = bus.instr[11:7];
        case (opc)
            OPC_OP, OPC_OPI: begin
                dec.use_imm   = (opc == OPC_OPI);
                dec.reg_write = 1'b1;
                if (opc == OPC_OPI)
                    dec.imm = {{20{bus.instr[31]}}, bus.instr[31:20]};
                case (f3)
                    3'b000: begin
                        // SUB only exists in register form
                        if (opc == OPC_OPI || f7 == F7_ZERO) dec.aluc = ALU_ADD;
                        else if (f7 == F7_ALT)               dec.aluc = ALU_SUB;
                        else                                 bad      = 1'b1;
                    end
                    3'b001: begin
                        dec.aluc = ALU_SLL;
                        if (opc == OPC_OPI) begin
                            dec.imm = {27'b0, bus.instr[24:20]};
                            bad     = (f7 != F7_ZERO);
                        end
                    end
                    3'b101: begin
                        if (opc == OPC_OPI) dec.imm = {27'b0, bus.instr[24:20]};
                        if (f7 == F7_ZERO)     dec.aluc = ALU_SRL;
                        else if (f7 == F7_ALT) dec.aluc = ALU_SRA;
                        else                   bad      = 1'b1;
                    end
                    3'b100:  dec.aluc = ALU_XOR;
                    3'b110:  dec.aluc = ALU_OR;
                    3'b111:  dec.aluc = ALU_AND;
                    default: bad      = 1'b1;   // SLT/SLTU family unsupported
                endcase
            end
            OPC_LUI: begin
                dec.aluc      = ALU_LUI;
                dec.imm       = {bus.instr[31:12], 12'b0};
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm       = {bus.instr[31:12], 12'b0};
                dec.use_pc    = 1'b1;
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_LD: begin
                dec.imm       = {{20{bus.instr[31]}}, bus.instr[31:20]};
                dec.use_imm   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_ST: begin
                dec.imm       = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
                dec.use_imm   = 1'b1;
                dec.mem_write = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        // Illegal keeps imm/register fields but neuters every side effect
        if (bad) begin
            dec.illegal   = 1'b1;
            dec.aluc      = ALU_ADD;
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.use_pc    = 1'b0;
        end
    end

    assign bus.in_ready = !vld || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
            vld  <= 1'b0;
            cnt  <= '0;
        end else if (bus.flush) begin
            vld <= 1'b0;
        end else if (accept) begin
            slot <= dec;
            vld  <= 1'b1;
            if (dec.illegal && cnt != '1) cnt <= cnt + CNT_W'(1);
        end else if (vld && bus.out_ready) begin
            vld <= 1'b0;
        end
    end

    assign bus.out_valid     = vld;
    assign bus.aluc          = slot.aluc;
    assign bus.imm           = slot.imm;
    assign bus.use_imm       = slot.use_imm;
    assign bus.use_pc        = slot.use_pc;
    assign bus.rs1           = slot.rs1;
    assign bus.rs2           = slot.rs2;
    assign bus.rd            = slot.rd;
    assign bus.reg_write     = slot.reg_write;
    assign bus.mem_read      = slot.mem_read;
    assign bus.mem_write     = slot.mem_write;
    assign bus.illegal       = slot.illegal;
    assign bus.illegal_count = cnt;
endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Directed-vector bench for alu_ctrl_decode; a second CNT_W=2 instance
// exercises counter saturation.
module tb_alu_ctrl_decode;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    localparam logic [31:0] I_ADD   = 32'h002081B3, I_SUB  = 32'h402081B3,
                            I_SRAI  = 32'h40435293, I_LUI  = 32'h123453B7,
                            I_SW    = 32'hFE20AE23, I_SLT  = 32'h003120B3,
                            I_AUIPC = 32'h00001097, I_ECALL = 32'h00000073,
                            I_BSLLI = 32'h40209093;

    always #5 clk = ~clk;

    alu_ctrl_decode_if #(.CNT_W(16)) d_if ();
    alu_ctrl_decode_if #(.CNT_W(2))  s_if ();

    alu_ctrl_decode #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(d_if));
    alu_ctrl_decode #(.CNT_W(2))  u_sat (.clk(clk), .rst(rst), .bus(s_if));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // advance one edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        d_if.in_valid = 1'b0; d_if.instr = '0; d_if.flush = 1'b0; d_if.out_ready = 1'b0;
        s_if.in_valid = 1'b0; s_if.instr = '0; s_if.flush = 1'b0; s_if.out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(d_if.out_valid), 32'd0);
        chk("rst_aluc",  32'(d_if.aluc), 32'd0);
        chk("rst_imm",   d_if.imm, 32'd0);
        chk("rst_rw",    32'(d_if.reg_write), 32'd0);
        chk("rst_cnt",   32'(d_if.illegal_count), 32'd0);
        chk("rst_ready", 32'(d_if.in_ready), 32'd1);

        rst = 1'b0; d_if.out_ready = 1'b1; d_if.in_valid = 1'b1;
        d_if.instr = I_ADD; tick();
        chk("add_valid", 32'(d_if.out_valid), 32'd1);
        chk("add_aluc",  32'(d_if.aluc), 32'b000000);
        chk("add_rs1",   32'(d_if.rs1), 32'd1);
        chk("add_rs2",   32'(d_if.rs2), 32'd2);
        chk("add_rd",    32'(d_if.rd), 32'd3);
        chk("add_rw",    32'(d_if.reg_write), 32'd1);
        chk("add_uimm",  32'(d_if.use_imm), 32'd0);

        d_if.instr = I_SUB; tick();
        chk("sub_aluc", 32'(d_if.aluc), 32'b001000);

        d_if.instr = I_SRAI; tick();
        chk("srai_aluc", 32'(d_if.aluc), 32'b011101);
        chk("srai_imm",  d_if.imm, 32'h00000004);
        chk("srai_uimm", 32'(d_if.use_imm), 32'd1);
        chk("srai_rd",   32'(d_if.rd), 32'd5);

        d_if.instr = I_LUI; tick();
        chk("lui_aluc", 32'(d_if.aluc), 32'b001100);
        chk("lui_imm",  d_if.imm, 32'h12345000);
        chk("lui_rd",   32'(d_if.rd), 32'd7);

        d_if.instr = I_AUIPC; tick();
        chk("auipc_aluc", 32'(d_if.aluc), 32'b000000);
        chk("auipc_imm",  d_if.imm, 32'h00001000);
        chk("auipc_pc",   32'(d_if.use_pc), 32'd1);

        d_if.instr = I_SW; tick();
        chk("sw_aluc", 32'(d_if.aluc), 32'b000000);
        chk("sw_imm",  d_if.imm, 32'hFFFFFFFC);
        chk("sw_mw",   32'(d_if.mem_write), 32'd1);
        chk("sw_rw",   32'(d_if.reg_write), 32'd0);
        chk("sw_rs1",  32'(d_if.rs1), 32'd1);
        chk("sw_rs2",  32'(d_if.rs2), 32'd2);

        d_if.instr = I_SLT; tick();
        chk("slt_ill",  32'(d_if.illegal), 32'd1);
        chk("slt_rw",   32'(d_if.reg_write), 32'd0);
        chk("slt_aluc", 32'(d_if.aluc), 32'b000000);
        chk("slt_cnt",  32'(d_if.illegal_count), 32'd1);

        d_if.instr = I_ECALL; tick();
        chk("ecall_ill", 32'(d_if.illegal), 32'd1);
        chk("ecall_cnt", 32'(d_if.illegal_count), 32'd2);

        d_if.instr = I_BSLLI; tick();
        chk("bslli_ill", 32'(d_if.illegal), 32'd1);
        chk("bslli_imm", d_if.imm, 32'h00000002);
        chk("bslli_cnt", 32'(d_if.illegal_count), 32'd3);

        // stall: slot holds ADD while SUB waits at the input
        d_if.instr = I_ADD; tick();
        d_if.out_ready = 1'b0; d_if.instr = I_SUB;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready", 32'(d_if.in_ready), 32'd0);
            chk("stall_valid", 32'(d_if.out_valid), 32'd1);
            chk("stall_aluc",  32'(d_if.aluc), 32'b000000);
        end
        d_if.out_ready = 1'b1;
        #1 chk("unstall_ready", 32'(d_if.in_ready), 32'd1);
        tick();
        chk("unstall_aluc",  32'(d_if.aluc), 32'b001000);
        chk("unstall_valid", 32'(d_if.out_valid), 32'd1);
        d_if.in_valid = 1'b0; tick();
        chk("drain_valid", 32'(d_if.out_valid), 32'd0);

        // flush with an illegal input while the slot is full
        d_if.in_valid = 1'b1; d_if.instr = I_ADD; d_if.out_ready = 1'b0; tick();
        chk("preflush_valid", 32'(d_if.out_valid), 32'd1);
        d_if.flush = 1'b1; d_if.instr = I_SLT; tick();
        chk("flush_valid", 32'(d_if.out_valid), 32'd0);
        chk("flush_cnt",   32'(d_if.illegal_count), 32'd3);
        d_if.flush = 1'b0; d_if.in_valid = 1'b0;

        // reset mid-stall
        d_if.in_valid = 1'b1; d_if.instr = I_LUI; tick();
        chk("prerst_valid", 32'(d_if.out_valid), 32'd1);
        rst = 1'b1; d_if.in_valid = 1'b0; tick();
        chk("mrst_valid", 32'(d_if.out_valid), 32'd0);
        chk("mrst_aluc",  32'(d_if.aluc), 32'd0);
        chk("mrst_imm",   d_if.imm, 32'd0);
        chk("mrst_rw",    32'(d_if.reg_write), 32'd0);
        chk("mrst_rd",    32'(d_if.rd), 32'd0);
        chk("mrst_cnt",   32'(d_if.illegal_count), 32'd0);
        rst = 1'b0;

        // saturation on the 2-bit counter
        s_if.instr = I_SLT; s_if.in_valid = 1'b1;
        tick(); tick();
        chk("sat_cnt2", 32'(s_if.illegal_count), 32'd2);
        tick(); tick(); tick();
        s_if.in_valid = 1'b0; tick();
        chk("sat_cnt5", 32'(s_if.illegal_count), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
